// File: rtl/lstm_seq_ctrl.sv
// Sequencer in front of the LSTM cell: takes one sample per timestep, holds the
// cell inputs stable for CELL_LATENCY cycles, captures the recurrent state and emits h.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRACT_WIDTH  = 8,
  parameter int CELL_LATENCY = 0,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_first,
  input  logic                  x_last,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last,
  output logic [CNT_W-1:0]      step_count,
  output logic                  seq_err
);

  // state  | meaning
  // S_IDLE | ready for the next sample
  // S_WAIT | cell inputs held, counting down the cell latency
  // S_OUT  | captured h_out offered downstream until accepted

  if (FRACT_WIDTH >= DATA_WIDTH || CELL_LATENCY < 0 || CELL_LATENCY > 15) begin : g_bad_param
    $error("lstm_seq_ctrl: illegal FRACT_WIDTH or CELL_LATENCY");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(CELL_LATENCY);

  state_t                state;
  logic [3:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [DATA_WIDTH-1:0] c_state;
  logic [DATA_WIDTH-1:0] h_state;
  logic                  last_reg;
  logic                  open;

  // The cell only ever sees registered values, never the live input stream.
  assign cell_x    = x_reg;
  assign cell_c_in = c_state;
  assign cell_h_in = h_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      x_reg      <= '0;
      c_state    <= '0;
      h_state    <= '0;
      last_reg   <= 1'b0;
      open       <= 1'b0;
      x_ready    <= 1'b0;
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_last     <= 1'b0;
      step_count <= '0;
      seq_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          x_ready <= 1'b1;
          if (x_valid && x_ready) begin
            x_reg    <= x_data;
            last_reg <= x_last;
            lat_cnt  <= LAT_LOAD;
            x_ready  <= 1'b0;
            state    <= S_WAIT;
            // A missing x_first on a closed sequence is flagged but still starts one.
            if (x_first || !open) begin
              c_state    <= '0;
              h_state    <= '0;
              step_count <= '0;
              open       <= 1'b1;
            end
            if (!x_first && !open) seq_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            c_state <= cell_c_out;
            h_state <= cell_h_out;
            y_data  <= cell_h_out;
            y_last  <= last_reg;
            y_valid <= 1'b1;
            if (step_count != {CNT_W{1'b1}}) step_count <= step_count + 1'b1;
            if (last_reg) open <= 1'b0;
            state <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            x_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          x_ready <= 1'b0;
          y_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: three instances (latency 0, 2, 5), each with its own
// delayed cell model (c_out = c_in + x, h_out = c_out + 0x10), driven by vector tables.
module tb_lstm_seq_ctrl;
  localparam int DW = 16;
  localparam int CW = 8;

  function automatic int lat(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 5);
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          x_valid [3];
  logic          x_ready [3];
  logic          x_first [3];
  logic          x_last  [3];
  logic          y_valid [3];
  logic          y_ready [3];
  logic          y_last  [3];
  logic          seq_err [3];
  logic [DW-1:0] x_data     [3];
  logic [DW-1:0] cell_x     [3];
  logic [DW-1:0] cell_c_in  [3];
  logic [DW-1:0] cell_h_in  [3];
  logic [DW-1:0] cell_c_out [3];
  logic [DW-1:0] cell_h_out [3];
  logic [DW-1:0] y_data     [3];
  logic [CW-1:0] step_count [3];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 5);
    logic [DW-1:0] c_now, h_now;

    lstm_seq_ctrl #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LATENCY(L), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst),
      .x_valid(x_valid[g]), .x_ready(x_ready[g]), .x_data(x_data[g]),
      .x_first(x_first[g]), .x_last(x_last[g]),
      .cell_x(cell_x[g]), .cell_c_in(cell_c_in[g]), .cell_h_in(cell_h_in[g]),
      .cell_c_out(cell_c_out[g]), .cell_h_out(cell_h_out[g]),
      .y_valid(y_valid[g]), .y_ready(y_ready[g]), .y_data(y_data[g]), .y_last(y_last[g]),
      .step_count(step_count[g]), .seq_err(seq_err[g])
    );

    assign c_now = cell_c_in[g] + cell_x[g];
    assign h_now = c_now + 16'h0010;

    if (L == 0) begin : g_comb
      assign cell_c_out[g] = c_now;
      assign cell_h_out[g] = h_now;
    end else begin : g_pipe
      logic [DW-1:0] c_pipe [L];
      logic [DW-1:0] h_pipe [L];
      always @(posedge clk) begin
        c_pipe[0] <= c_now;
        h_pipe[0] <= h_now;
        for (int k = 1; k < L; k++) begin
          c_pipe[k] <= c_pipe[k-1];
          h_pipe[k] <= h_pipe[k-1];
        end
      end
      assign cell_c_out[g] = c_pipe[L-1];
      assign cell_h_out[g] = h_pipe[L-1];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            inst;
    logic [DW-1:0] x;
    logic          first;
    logic          last;
    logic [DW-1:0] exp_cin;
    logic [DW-1:0] exp_hin;
    logic [DW-1:0] exp_y;
    logic          exp_last;
    logic [CW-1:0] exp_cnt;
    logic          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic wait_ready(input int i, input string tag);
    bit got = 0;
    for (int n = 0; n < 50; n++) begin
      if (x_ready[i]) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk({tag, ".x_ready_wait"}, 32'(got), 1);
  endtask

  task automatic do_step(input vec_t v, input string tag);
    int i = v.inst;
    int n;
    wait_ready(i, tag);
    x_valid[i] = 1'b1; x_data[i] = v.x; x_first[i] = v.first; x_last[i] = v.last;
    @(posedge clk); #1;
    x_valid[i] = 1'b0; x_data[i] = '0; x_first[i] = 1'b0; x_last[i] = 1'b0;
    chk({tag, ".x_ready_low"}, 32'(x_ready[i]), 0);
    chk({tag, ".cell_x"}, 32'(cell_x[i]), 32'(v.x));
    chk({tag, ".cell_c_in"}, 32'(cell_c_in[i]), 32'(v.exp_cin));
    chk({tag, ".cell_h_in"}, 32'(cell_h_in[i]), 32'(v.exp_hin));
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (y_valid[i]) break;
    end
    chk({tag, ".capture_edge"}, 32'(n), 32'(lat(i) + 1));
    chk({tag, ".y_data"}, 32'(y_data[i]), 32'(v.exp_y));
    chk({tag, ".y_last"}, 32'(y_last[i]), 32'(v.exp_last));
    chk({tag, ".step_count"}, 32'(step_count[i]), 32'(v.exp_cnt));
    chk({tag, ".seq_err"}, 32'(seq_err[i]), 32'(v.exp_err));
    if (y_ready[i]) begin
      @(posedge clk); #1;
      chk({tag, ".y_valid_drop"}, 32'(y_valid[i]), 0);
      chk({tag, ".x_ready_rise"}, 32'(x_ready[i]), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            inst  x          f     l     cin        hin        y          last  cnt    err
    vecs[0] = '{0, 16'h0100, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0110, 1'b1, 8'd1, 1'b0};
    vecs[1] = '{1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0110, 1'b0, 8'd1, 1'b0};
    vecs[2] = '{1, 16'h0080, 1'b0, 1'b0, 16'h0100, 16'h0110, 16'h0190, 1'b0, 8'd2, 1'b0};
    vecs[3] = '{1, 16'h0040, 1'b0, 1'b1, 16'h0180, 16'h0190, 16'h01D0, 1'b1, 8'd3, 1'b0};
    vecs[4] = '{1, 16'h0300, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0310, 1'b0, 8'd1, 1'b0};
    vecs[5] = '{1, 16'h0010, 1'b0, 1'b0, 16'h0300, 16'h0310, 16'h0320, 1'b0, 8'd2, 1'b0};
    vecs[6] = '{1, 16'h0040, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0050, 1'b0, 8'd1, 1'b0};
    vecs[7] = '{1, 16'h0020, 1'b0, 1'b1, 16'h0040, 16'h0050, 16'h0070, 1'b1, 8'd2, 1'b0};
    vecs[8] = '{2, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0110, 1'b0, 8'd1, 1'b1};
    vecs[9] = '{2, 16'h0200, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0210, 1'b0, 8'd1, 1'b1};

    for (int i = 0; i < 3; i++) begin
      x_valid[i] = 1'b0; x_first[i] = 1'b0; x_last[i] = 1'b0;
      x_data[i] = '0; y_ready[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.x_ready", i), 32'(x_ready[i]), 0);
      chk($sformatf("rst%0d.y_valid", i), 32'(y_valid[i]), 0);
      chk($sformatf("rst%0d.y_data", i), 32'(y_data[i]), 0);
      chk($sformatf("rst%0d.y_last", i), 32'(y_last[i]), 0);
      chk($sformatf("rst%0d.step_count", i), 32'(step_count[i]), 0);
      chk($sformatf("rst%0d.seq_err", i), 32'(seq_err[i]), 0);
      chk($sformatf("rst%0d.cell_c_in", i), 32'(cell_c_in[i]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) do_step(vecs[k], $sformatf("vec%0d", k));

    // Backpressure: output held for 5 cycles, a stray x_valid pulse must be ignored.
    y_ready[1] = 1'b0;
    do_step('{1, 16'h0007, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0017, 1'b1, 8'd1, 1'b0}, "bp");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.hold%0d.y_valid", k), 32'(y_valid[1]), 1);
      chk($sformatf("bp.hold%0d.y_data", k), 32'(y_data[1]), 32'h0017);
      chk($sformatf("bp.hold%0d.x_ready", k), 32'(x_ready[1]), 0);
      if (k == 1) begin x_valid[1] = 1'b1; x_data[1] = 16'h7777; x_first[1] = 1'b1; end
      if (k == 2) begin x_valid[1] = 1'b0; x_data[1] = '0; x_first[1] = 1'b0; end
      @(posedge clk); #1;
    end
    y_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp.release.y_valid", 32'(y_valid[1]), 0);
    chk("bp.release.x_ready", 32'(x_ready[1]), 1);
    chk("bp.release.step_count", 32'(step_count[1]), 1);
    chk("bp.release.cell_x", 32'(cell_x[1]), 32'h0007);

    // Async reset two cycles into a latency-5 wait.
    wait_ready(2, "arst");
    x_valid[2] = 1'b1; x_data[2] = 16'h0050; x_first[2] = 1'b0; x_last[2] = 1'b0;
    @(posedge clk); #1;
    x_valid[2] = 1'b0; x_data[2] = '0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("arst.pre.cell_c_in", 32'(cell_c_in[2]), 32'h0200);
    rst = 1'b1;
    #1;
    chk("arst.y_valid", 32'(y_valid[2]), 0);
    chk("arst.step_count", 32'(step_count[2]), 0);
    chk("arst.seq_err", 32'(seq_err[2]), 0);
    chk("arst.x_ready", 32'(x_ready[2]), 0);
    chk("arst.cell_c_in", 32'(cell_c_in[2]), 0);
    chk("arst.cell_x", 32'(cell_x[2]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_step('{2, 16'h0200, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0210, 1'b0, 8'd1, 1'b0}, "arst.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
